// File: rtl/key_pio_pkg.sv
// key_pio_pkg: shared FSM states and constants for the key PIO poller.
package key_pio_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, UPDATE} state_t;
  localparam logic [1:0] KEY_ADDR_DATA = 2'd0;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: per-sample debounce of active-high key samples plus press detection.
module key_debounce import key_pio_pkg::*; #(
  parameter int KEY_WIDTH    = 4,
  parameter int STABLE_COUNT = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sample,
  input  logic [KEY_WIDTH-1:0] raw,
  output logic [KEY_WIDTH-1:0] key_state,
  output logic [KEY_WIDTH-1:0] new_press
);
  logic [KEY_WIDTH-1:0] last_raw;
  logic [KEY_WIDTH-1:0] state_next;
  logic [CNT_W-1:0]     stable_cnt;
  logic [CNT_W-1:0]     cnt_next;
  always_comb begin
    cnt_next   = raw != last_raw ? CNT_W'(1) : stable_cnt == CNT_MAX ? CNT_MAX : stable_cnt + 1'b1;
    state_next = sample && cnt_next >= CNT_W'(STABLE_COUNT) ? raw : key_state;
    new_press  = state_next & ~key_state;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      last_raw   <= '0;
      stable_cnt <= '0;
      key_state  <= '0;
    end else if (sample) begin
      last_raw   <= raw;
      stable_cnt <= cnt_next;
      key_state  <= state_next;
    end
endmodule

// File: rtl/key_pio_poller.sv
// key_pio_poller: periodic Avalon-MM reader of the key PIO producing debounced state and press events.
module key_pio_poller import key_pio_pkg::*; #(
  parameter int POLL_PERIOD  = 50000,
  parameter int STABLE_COUNT = 4,
  parameter int KEY_WIDTH    = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic [1:0]           avm_address,
  output logic                 avm_read,
  input  logic                 avm_waitrequest,
  input  logic [31:0]          avm_readdata,
  output logic [KEY_WIDTH-1:0] key_state,
  output logic [KEY_WIDTH-1:0] key_event,
  output logic                 key_event_valid,
  input  logic                 key_event_ready
);
  localparam int TW = $clog2(POLL_PERIOD);
  localparam int LW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;
  state_t               state, state_next;
  logic [TW-1:0]        timer;
  logic [LW-1:0]        lat;
  logic                 wrap, poll_req, capture, go;
  logic [KEY_WIDTH-1:0] raw, new_press;
  logic                 unused_data;
  assign unused_data     = ^avm_readdata;
  assign avm_address     = KEY_ADDR_DATA;
  assign avm_read        = state == REQ;
  assign wrap            = timer == TW'(POLL_PERIOD - 1);
  assign capture         = state == WAIT && lat == LW'(READ_LATENCY - 1);
  assign go              = state == IDLE && (poll_req || wrap);
  assign key_event_valid = |key_event;
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = go ? REQ : IDLE;
      REQ:     state_next = avm_waitrequest ? REQ : WAIT;
      WAIT:    state_next = capture ? UPDATE : WAIT;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  // A wrap seen in IDLE is consumed immediately; one seen while busy waits as a single request.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      poll_req  <= 1'b0;
      lat       <= '0;
      raw       <= '0;
      key_event <= '0;
    end else begin
      state     <= state_next;
      timer     <= wrap ? '0 : timer + 1'b1;
      poll_req  <= go ? 1'b0 : poll_req | wrap;
      lat       <= state == WAIT ? lat + 1'b1 : '0;
      raw       <= capture ? ~avm_readdata[KEY_WIDTH-1:0] : raw;
      key_event <= (key_event_valid && key_event_ready ? '0 : key_event) | new_press;
    end
  key_debounce #(.KEY_WIDTH(KEY_WIDTH), .STABLE_COUNT(STABLE_COUNT)) u_debounce (
    .clk       (clk),
    .reset_n   (reset_n),
    .sample    (state == UPDATE),
    .raw       (raw),
    .key_state (key_state),
    .new_press (new_press)
  );
endmodule

// File: doc/key_pio_poller.md
# key_pio_poller

Avalon-MM initiator that periodically reads the 4-bit key PIO data register (address 0, fixed read latency 1, no `readdatavalid`). It debounces the active-low key samples and produces debounced key state plus sticky key-press events behind a valid/ready handshake. It sits between the key PIO responder and the game-control logic, so software polling of the keys is not needed.

## Interface
Parameters:
- `POLL_PERIOD`, default 50000: clock cycles between poll requests (1 ms at 50 MHz); legal range ≥ 4.
- `STABLE_COUNT`, default 4: consecutive identical samples required before the debounced state updates; legal range 1..15.
- `KEY_WIDTH`, default 4: number of keys, taken from `readdata[KEY_WIDTH-1:0]`.
- `READ_LATENCY`, default 1: cycles from accepted read to valid `readdata`.

Ports:
- `clk`, input, 1: sole clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `avm_address`, output, 2: always 2'd0.
- `avm_read`, output, 1: read request.
- `avm_waitrequest`, input, 1: responder stall. Tie to 0 for the PIO.
- `avm_readdata`, input, 32: read data.
- `key_state`, output, KEY_WIDTH: debounced state, 1 = pressed.
- `key_event`, output, KEY_WIDTH: pending press events, one bit per key.
- `key_event_valid`, output, 1: `key_event` is nonzero.
- `key_event_ready`, input, 1: consumer accepts the event.

## Operation
- Poll timer counts 0..POLL_PERIOD-1 and wraps. On wrap it sets `poll_req`. `poll_req` clears when the FSM leaves IDLE. A wrap that occurs while the FSM is busy keeps `poll_req` set; requests never queue deeper than one.
- FSM states:
  - IDLE: when `poll_req` is set → REQ.
  - REQ: `avm_read`=1. Stays in REQ while `avm_waitrequest`=1. When `avm_waitrequest`=0 the read is accepted → WAIT.
  - WAIT: a latency counter counts READ_LATENCY cycles after acceptance. On the capture cycle, latch `raw = ~avm_readdata[KEY_WIDTH-1:0]` → UPDATE.
  - UPDATE: debounce and edge step → IDLE.
- `avm_read` is high only in REQ.
- Debounce:
  - If `raw` equals `last_raw`, `stable_cnt` increments, saturating at 15.
  - Otherwise `stable_cnt` is set to 1 and `last_raw` takes `raw`.
  - When `stable_cnt` ≥ STABLE_COUNT, `key_state` takes `last_raw`.
- Press detect: `new_press = key_state_next & ~key_state`. Releases produce no event.
- Event register, updated every cycle:
  - `pending_next = (valid && ready ? 0 : pending) | new_press`.
  - A press that coincides with a handshake is never lost.
  - Repeated presses of one key while it is still pending merge into a single event.
- `key_event_valid = |pending`. `key_event` is `pending`.
- Reset values of all registers and outputs:
  - `avm_read`=0, `avm_address`=0.
  - `key_state`=0, `key_event`=0, `key_event_valid`=0.
  - `last_raw`=0 (released), `stable_cnt`=0.
  - Timer=0, FSM=IDLE, `poll_req`=0.
- If reset asserts mid-transaction, the read is abandoned immediately. No response is expected after reset.

## Timing
- First poll request occurs POLL_PERIOD cycles after reset deassertion.
- With `avm_waitrequest`=0:
  - REQ at cycle N.
  - Data captured at N+READ_LATENCY.
  - UPDATE at N+READ_LATENCY+1.
  - `key_state` and `pending` change at N+READ_LATENCY+2.
- Minimum press-to-event latency is STABLE_COUNT polls.
- `key_event_valid` stays asserted until a handshake with `key_event_ready` occurs. A handshake clears it on the next edge unless a new press arrives in the same cycle.
- `key_event_ready` may be held high permanently. Events then last one cycle.

## Structure
- The package `key_pio_pkg` holds:
  - the FSM state enum (IDLE, REQ, WAIT, UPDATE);
  - the `KEY_ADDR_DATA`=2'd0 constant;
  - the stable-counter width (4).
- One sub-module, `key_debounce`: per-sample debounce plus press detect, fed by a sample strobe and `raw`, producing `key_state` and `new_press`.
- Timer, FSM and event register live in the top level.

## Test plan
- Reset: hold `reset_n`=0 → all outputs 0. First `avm_read` appears exactly POLL_PERIOD cycles after reset release (POLL_PERIOD=8 in the bench).
- Clean press: responder returns `readdata`=32'hE (key0 pressed) for 4 polls with STABLE_COUNT=4 → `key_state`=4'h1 after the 4th poll, `key_event`=4'h1, `key_event_valid`=1 until the ready handshake.
- Bounce: samples F,E,F,E,E,E,E → no event until the 4th consecutive E, then exactly one event for key0.
- Waitrequest: hold `avm_waitrequest`=1 for 20 cycles with POLL_PERIOD=8 → `avm_read` stays high the whole time and `avm_address`=0. Only one read completes after release, and `poll_req` is then re-serviced once.
- Simultaneous handshake and new press: `pending`=4'h1, `key_event_ready`=1 in the same cycle key1's press is detected → next `key_event`=4'h2, `key_event_valid`=1.
- Reset mid-read: assert `reset_n`=0 during WAIT → `avm_read`=0 and the FSM is in IDLE. After release, normal polling resumes with `key_state`=0.
